// File: rtl/famicom_pad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : famicom_pad_emulator
// Brief    : Famicom/NES pad emulator with ASCII key injection. Serialises the
//            joystick state, or queued key bytes, onto famicom_data in
//            response to latch/pulse strobes arriving from the core domain.
// Revision : 1.0 - initial release
// ============================================================================
module famicom_pad_emulator #(
  parameter int DEPTH        = 4,
  parameter int HOLD_LATCHES = 2,
  parameter int GAP_LATCHES  = 2,
  parameter int CNT_W        = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [7:0]               joystick,
  input  logic                     key_valid,
  input  logic [7:0]               key_data,
  output logic                     key_ready,
  input  logic                     famicom_latch,
  input  logic                     famicom_pulse,
  output logic                     famicom_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int c_ptr_w = $clog2(DEPTH);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_key  = 2'd1;
  localparam logic [1:0] c_st_gap  = 2'd2;

  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_LATCHES - 1);
  localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_LATCHES - 1);
  localparam logic [c_ptr_w:0] c_full      = (c_ptr_w + 1)'(DEPTH);
  localparam logic [7:0]       c_idle_byte = 8'hFF;

  // Synchroniser and edge-detect registers
  logic r_latch_s1, r_latch_s2, r_latch_prev;
  logic r_pulse_s1, r_pulse_s2, r_pulse_prev;
  logic w_latch_rise, w_pulse_rise;

  // Serialiser and sequencing state
  logic [7:0]       r_shift;
  logic [1:0]       r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic [7:0]       w_load_byte;
  logic             w_pop_req, w_pop;

  // Key FIFO
  logic [7:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_ptr_w:0]   r_level;
  logic               w_push, w_fifo_empty;
  logic [7:0]         w_head;

  // Bring latch and pulse into clk_sys and keep the previous synced value
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_latch_s1   <= 1'b0;
      r_latch_s2   <= 1'b0;
      r_latch_prev <= 1'b0;
      r_pulse_s1   <= 1'b0;
      r_pulse_s2   <= 1'b0;
      r_pulse_prev <= 1'b0;
    end else begin
      r_latch_s1   <= famicom_latch;
      r_latch_s2   <= r_latch_s1;
      r_latch_prev <= r_latch_s2;
      r_pulse_s1   <= famicom_pulse;
      r_pulse_s2   <= r_pulse_s1;
      r_pulse_prev <= r_pulse_s2;
    end
  end

  // A pulse is only honoured while latch is low; a simultaneous latch edge
  // takes priority further down in the shift register.
  assign w_latch_rise = r_latch_s2 & ~r_latch_prev;
  assign w_pulse_rise = r_pulse_s2 & ~r_pulse_prev & ~r_latch_s2;

  assign w_fifo_empty = (r_level == '0);
  assign w_head       = r_mem[r_rd_ptr];

  // Choose the wire byte and next sequencing state for the next latch event
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pop_req    = 1'b0;
    w_load_byte  = ~joystick;
    case (r_state)
      c_st_idle: begin
        if (!w_fifo_empty) begin
          w_load_byte = w_head;
          if (HOLD_LATCHES == 1) begin
            w_pop_req    = 1'b1;
            w_next_cnt   = '0;
            w_next_state = c_st_gap;
          end else begin
            w_next_cnt   = CNT_W'(1);
            w_next_state = c_st_key;
          end
        end
      end
      c_st_key: begin
        w_load_byte = w_head;
        if (r_cnt == c_hold_last) begin
          w_pop_req    = 1'b1;
          w_next_cnt   = '0;
          w_next_state = c_st_gap;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      c_st_gap: begin
        w_load_byte = c_idle_byte;
        if (r_cnt == c_gap_last) begin
          w_next_cnt   = '0;
          w_next_state = c_st_idle;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_load_byte  = c_idle_byte;
        w_next_cnt   = '0;
        w_next_state = c_st_idle;
      end
    endcase
  end

  assign w_pop = w_latch_rise & w_pop_req;

  // Sequencer advances only on latch events
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else if (w_latch_rise) begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Load on latch, shift left filling with 1 on pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= 8'hFF;
    end else if (w_latch_rise) begin
      r_shift <= w_load_byte;
    end else if (w_pulse_rise) begin
      r_shift <= {r_shift[6:0], 1'b1};
    end
  end

  assign famicom_data = r_shift[7];

  assign key_ready = (r_level != c_full);
  assign w_push    = key_valid & key_ready;

  // Key storage; contents are don't-care while the entry is unoccupied
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= key_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (c_ptr_w + 1)'(1);
        2'b01:   r_level <= r_level - (c_ptr_w + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign fifo_level = r_level;
  assign busy       = (r_state != c_st_idle) | ~w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_famicom_pad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_famicom_pad_emulator
// Brief    : Directed self-checking bench for famicom_pad_emulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_famicom_pad_emulator;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [7:0] joystick;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_ready;
  logic       famicom_latch;
  logic       famicom_pulse;
  logic       famicom_data;
  logic [2:0] fifo_level;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  famicom_pad_emulator #(
    .DEPTH(4), .HOLD_LATCHES(2), .GAP_LATCHES(2), .CNT_W(4)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .joystick      (joystick),
    .key_valid     (key_valid),
    .key_data      (key_data),
    .key_ready     (key_ready),
    .famicom_latch (famicom_latch),
    .famicom_pulse (famicom_pulse),
    .famicom_data  (famicom_data),
    .fifo_level    (fifo_level),
    .busy          (busy)
  );

  always #10 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // One latch + 8 pulses; pre is the line 2 cycles after latch rise,
  // b is the captured byte, tail is the line after the 8th pulse.
  task automatic run_frame(output logic [7:0] b, output logic pre, output logic tail);
    famicom_latch = 1'b1;
    wait_clks(2);
    pre = famicom_data;
    wait_clks(1);
    b[7] = famicom_data;
    wait_clks(3);
    famicom_latch = 1'b0;
    wait_clks(4);
    for (int i = 6; i >= -1; i--) begin
      famicom_pulse = 1'b1;
      wait_clks(5);
      if (i >= 0) b[i] = famicom_data;
      else        tail = famicom_data;
      famicom_pulse = 1'b0;
      wait_clks(4);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    key_data  = d;
    key_valid = 1'b1;
    wait_clks(1);
    key_valid = 1'b0;
  endtask

  logic [7:0] fb;
  logic       fpre, ftail;
  logic [7:0] keys [5];
  logic [7:0] exp_b;

  initial begin
    reset_n       = 1'b0;
    joystick      = 8'h00;
    key_valid     = 1'b0;
    key_data      = 8'h00;
    famicom_latch = 1'b0;
    famicom_pulse = 1'b0;
    wait_clks(3);
    check_val("rst_data",  famicom_data, 1);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_ready", key_ready, 1);
    check_val("rst_busy",  busy, 0);
    reset_n = 1'b1;
    wait_clks(2);

    // Released pad reads all ones, line stays 1 after shifting out
    run_frame(fb, fpre, ftail);
    check_val("joy00_byte", fb, 8'hFF);
    check_val("joy00_tail", ftail, 1);

    // A+Right -> 0x7E, first bit appears exactly 3 cycles after latch
    joystick = 8'h81;
    run_frame(fb, fpre, ftail);
    check_val("joy81_pre",  fpre, 1);
    check_val("joy81_byte", fb, 8'h7E);
    check_val("joy81_tail", ftail, 1);

    // Single key: 41,41,FF,FF then joystick
    joystick = 8'h00;
    push_byte(8'h41);
    check_val("k1_level", fifo_level, 1);
    check_val("k1_busy",  busy, 1);
    for (int f = 0; f < 6; f++) begin
      run_frame(fb, fpre, ftail);
      exp_b = (f < 2) ? 8'h41 : 8'hFF;
      check_val($sformatf("k1_frame%0d", f), fb, exp_b);
      if (f == 2) check_val("k1_busy_f2", busy, 1);
      if (f == 3) check_val("k1_busy_f3", busy, 0);
    end

    // Overfill a 4-deep FIFO; the 5th byte must be refused
    joystick = 8'h81;
    keys[0] = 8'h10; keys[1] = 8'h22; keys[2] = 8'h33; keys[3] = 8'h44; keys[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      key_data  = keys[i];
      key_valid = 1'b1;
      wait_clks(1);
    end
    key_valid = 1'b0;
    check_val("full_level", fifo_level, 4);
    check_val("full_ready", key_ready, 0);
    for (int f = 0; f < 17; f++) begin
      run_frame(fb, fpre, ftail);
      if (f == 16)          exp_b = 8'h7E;
      else if (f % 4 < 2)   exp_b = keys[f / 4];
      else                  exp_b = 8'hFF;
      check_val($sformatf("full_frame%0d", f), fb, exp_b);
      if (f == 0) check_val("full_ready_f0", key_ready, 0);
      if (f == 1) begin
        check_val("full_ready_f1", key_ready, 1);
        check_val("full_level_f1", fifo_level, 3);
      end
    end
    check_val("full_busy_end", busy, 0);

    // Simultaneous latch+pulse: load wins; pulses while latch high ignored
    joystick      = 8'h80;
    famicom_latch = 1'b1;
    famicom_pulse = 1'b1;
    wait_clks(6);
    check_val("same_load", famicom_data, 0);
    famicom_pulse = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 3; i++) begin
      famicom_pulse = 1'b1;
      wait_clks(5);
      check_val($sformatf("hold_pulse%0d", i), famicom_data, 0);
      famicom_pulse = 1'b0;
      wait_clks(4);
    end
    famicom_latch = 1'b0;
    wait_clks(4);

    // Reset in the middle of a key hold with a second byte queued
    joystick = 8'h81;
    push_byte(8'h41);
    push_byte(8'h42);
    run_frame(fb, fpre, ftail);
    check_val("mid_frame0", fb, 8'h41);
    famicom_latch = 1'b1;
    wait_clks(4);
    check_val("mid_pre_data", famicom_data, 0);
    #3 reset_n = 1'b0;
    #1;
    check_val("mid_rst_data",  famicom_data, 1);
    check_val("mid_rst_level", fifo_level, 0);
    check_val("mid_rst_busy",  busy, 0);
    check_val("mid_rst_ready", key_ready, 1);
    famicom_latch = 1'b0;
    wait_clks(2);
    reset_n = 1'b1;
    wait_clks(4);
    run_frame(fb, fpre, ftail);
    check_val("post_rst_joy", fb, 8'h7E);
    check_val("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/famicom_pad_emulator.md
Name: famicom_pad_emulator

Overview:
- Upstream feeder for the Gigatron core's serial game-controller input (famicom_latch / famicom_pulse / famicom_data).
- Emulates a Famicom/NES pad plus ASCII-injection adapter: serialises the MiSTer joystick state, or queued keyboard bytes, onto famicom_data in response to the core's latch/pulse strobes.
- Latch and pulse arrive from the 6.25 MHz Gigatron domain and are synchronised into clk_sys.

Parameters:
- DEPTH, 4, key FIFO entries (power of two, 2..16)
- HOLD_LATCHES, 2, latch events each key byte is presented (>=1)
- GAP_LATCHES, 2, latch events of idle 0xFF after each key byte (>=1)
- CNT_W, 4, width of the latch-event counter (must hold max(HOLD_LATCHES, GAP_LATCHES))

Ports:
- clk_sys  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- joystick  in  8  pressed buttons, active high: [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right
- key_valid  in  1  key_data holds a byte to enqueue
- key_data  in  8  ASCII byte, sent raw
- key_ready  out  1  FIFO not full; push occurs when key_valid & key_ready
- famicom_latch  in  1  latch strobe from core, async to clk_sys
- famicom_pulse  in  1  shift clock from core, async to clk_sys
- famicom_data  out  1  serial data to core; line level equals wire-byte bit, MSB first
- fifo_level  out  log2(DEPTH)+1  current FIFO occupancy
- busy  out  1  state != IDLE or FIFO not empty

Behaviour:
- Reset (async, reset_n low): famicom_data=1; shift register=8'hFF; FIFO empty; fifo_level=0; key_ready=1; busy=0; state=IDLE; counter=0; synchroniser flops=0.
- Synchronisation: latch and pulse each pass through a 2-flop synchroniser plus an edge register. A rising edge is detected when sync=1 and previous=0. Edge-to-data-change latency is 3 clk_sys cycles.
- Wire byte definitions:
  - JOY = ~joystick, sampled in the detection cycle (released pad reads 0xFF).
  - KEY = FIFO head, not inverted.
  - IDLE_BYTE = 8'hFF.
- Latch rising edge: shift register loads the selected wire byte; famicom_data = bit 7 on the next cycle.
- Pulse rising edge with latch sync low: shift register shifts left, filling with 1; famicom_data follows the new bit 7. After 8 or more shifts the line reads 1.
- Pulse rising edge while latch sync is high: ignored.
- Latch and pulse edges detected in the same cycle: the load wins and the shift is dropped.
- FSM (transitions occur only on latch rising edges):
  - IDLE: FIFO empty -> load JOY, stay in IDLE. FIFO non-empty -> load KEY, counter=1; if HOLD_LATCHES==1, pop and go to GAP with counter=0, else go to KEY.
  - KEY: load KEY. If counter==HOLD_LATCHES-1: pop, counter=0, go to GAP. Otherwise counter+1.
  - GAP: load IDLE_BYTE (joystick ignored). If counter==GAP_LATCHES-1: counter=0, go to IDLE. Otherwise counter+1.
- FIFO:
  - Push and pop in the same cycle leave occupancy unchanged.
  - key_ready is combinational from occupancy.
  - Push while full is impossible, since ready is low.
  - Pop only ever occurs with FIFO non-empty.
  - Pointers wrap modulo DEPTH.
- Joystick changes between latches have no effect on an in-progress shift-out.
- Reset mid-shift or mid-key: everything returns to reset values immediately; the queued bytes are lost.

Test Plan:
- Reset, then latch edge with joystick=8'h00, then 8 pulses -> famicom_data reads 1 for every bit, then stays 1.
- joystick=8'h81 (A+Right), latch, then 8 pulses -> bit sequence on famicom_data is 0,1,1,1,1,1,1,0; first bit valid 3 clk_sys after latch rise.
- Push 0x41 with defaults, then 6 latch/8-pulse frames with joystick=0 -> frames read 0x41, 0x41, 0xFF, 0xFF, 0xFF(JOY), 0xFF; busy drops after frame 4.
- Push 5 bytes back-to-back with DEPTH=4 -> key_ready=0 after the 4th, 5th not accepted, fifo_level=4; first pop (after 2nd latch) raises key_ready; frames deliver the 4 bytes in order, each held 2 frames with 2-frame gaps.
- Latch and pulse rising in the same synchronised cycle -> register loads, no shift; latch held high with 3 pulses -> famicom_data stays at bit 7.
- Assert reset_n low mid-KEY with 2 bytes queued -> famicom_data=1, fifo_level=0, busy=0 asynchronously; next frame returns JOY.
